// File: rtl/priority_arbiter_pkg.sv
// Shared types and sizing for the eight-requester priority arbiter.
package priority_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

endpackage

// File: rtl/priority_deshiphrator.sv
// 8->3 priority encoder: index of the highest set bit, 0 when no bit is set.
module priority_deshiphrator
  import priority_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  output logic [IDX_W-1:0] idx
);

  // Later (higher) set bits overwrite earlier ones, so the highest index wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Fixed-priority bus arbiter with bounded tenure and one-round preemption mask.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             preempt
);

  state_t            state;
  logic [NREQ-1:0]   mask;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   sel;
  logic              sel_any;
  logic [IDX_W-1:0]  win;
  logic [HOLD_W-1:0] cnt;

  // A masked requester only loses to others; alone it still wins.
  assign eligible = req & ~mask;
  assign sel      = (|eligible) ? eligible : req;
  assign sel_any  = |sel;

  priority_deshiphrator u_enc (
    .vec (sel),
    .idx (win)
  );

  // One-hot grant decoded purely from flops.
  assign grant = NREQ'(busy) << grant_idx;

  // Arbitration / tenure state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      busy      <= 1'b0;
      preempt   <= 1'b0;
      mask      <= '0;
      cnt       <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant_idx <= win;
            busy      <= 1'b1;
            cnt       <= HOLD_W'(1);
            mask      <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done || !req[grant_idx]) begin
            busy  <= 1'b0;
            state <= GAP;
          end else if (cnt == HOLD_W'(MAX_HOLD)) begin
            busy    <= 1'b0;
            mask    <= NREQ'(1) << grant_idx;
            preempt <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: vector table plus multi-cycle sequences.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       preempt;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] idx;
    logic       b;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  priority_arbiter #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .preempt   (preempt)
  );

  function automatic void add(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic [2:0] i,
                              input logic b, input logic p);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d; v.g = g; v.idx = i; v.b = b; v.p = p;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst_n = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] g, input logic [2:0] i,
                       input logic b, input logic p);
    nvec++;
    if (grant !== g || grant_idx !== i || busy !== b || preempt !== p) begin
      nmis++;
      $display("FAIL %s: got grant=%h idx=%0d busy=%b preempt=%b, want grant=%h idx=%0d busy=%b preempt=%b",
               name, grant, grant_idx, busy, preempt, g, i, b, p);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0;

    //  rst   req    done  grant  idx b  p
    add(1'b0, 8'h00, 1'b0, 8'h00, 0, 0, 0);  // reset
    add(1'b0, 8'h00, 1'b0, 8'h00, 0, 0, 0);
    add(1'b1, 8'h24, 1'b0, 8'h20, 5, 1, 0);  // highest of 0010_0100 wins
    add(1'b1, 8'h24, 1'b1, 8'h00, 5, 0, 0);  // done -> GAP
    add(1'b1, 8'h04, 1'b0, 8'h00, 5, 0, 0);  // IDLE, idx held
    add(1'b1, 8'h04, 1'b0, 8'h04, 2, 1, 0);  // req[2] granted
    add(1'b1, 8'h04, 1'b0, 8'h04, 2, 1, 0);
    add(1'b1, 8'h04, 1'b1, 8'h00, 2, 0, 0);
    add(1'b1, 8'h88, 1'b0, 8'h00, 2, 0, 0);
    add(1'b1, 8'h88, 1'b0, 8'h80, 7, 1, 0);
    add(1'b1, 8'h88, 1'b0, 8'h80, 7, 1, 0);
    add(1'b1, 8'h08, 1'b0, 8'h00, 7, 0, 0);  // req[7] dropped -> release, no preempt
    add(1'b1, 8'h08, 1'b0, 8'h00, 7, 0, 0);
    add(1'b1, 8'h08, 1'b0, 8'h08, 3, 1, 0);
    add(1'b0, 8'h08, 1'b0, 8'h00, 0, 0, 0);  // reset mid-tenure
    add(1'b1, 8'h01, 1'b0, 8'h01, 0, 1, 0);
    add(1'b1, 8'h01, 1'b1, 8'h00, 0, 0, 0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 0, 0, 0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 0, 0, 0);  // nothing pending, stays idle

    foreach (tbl[k]) begin
      step(tbl[k].rst_n, tbl[k].req, tbl[k].done);
      check($sformatf("row%0d", k), tbl[k].g, tbl[k].idx, tbl[k].b, tbl[k].p);
    end

    // All requesting, no done: 7 expires after 16 cycles, 6 gets a turn, then 7 again.
    step(1'b1, 8'hFF, 1'b0);
    check("ff_win7", 8'h80, 7, 1, 0);
    for (int c = 0; c < 15; c++) begin
      step(1'b1, 8'hFF, 1'b0);
      check($sformatf("ff_hold7_%0d", c), 8'h80, 7, 1, 0);
    end
    step(1'b1, 8'hFF, 1'b0);
    check("ff_preempt7", 8'h00, 7, 0, 1);
    step(1'b1, 8'hFF, 1'b0);
    check("ff_idle1", 8'h00, 7, 0, 0);
    step(1'b1, 8'hFF, 1'b0);
    check("ff_win6", 8'h40, 6, 1, 0);
    for (int c = 0; c < 15; c++) begin
      step(1'b1, 8'hFF, 1'b0);
      check($sformatf("ff_hold6_%0d", c), 8'h40, 6, 1, 0);
    end
    step(1'b1, 8'hFF, 1'b0);
    check("ff_preempt6", 8'h00, 6, 0, 1);
    step(1'b1, 8'hFF, 1'b0);
    check("ff_idle2", 8'h00, 6, 0, 0);
    step(1'b1, 8'hFF, 1'b0);
    check("ff_win7_again", 8'h80, 7, 1, 0);
    step(1'b1, 8'hFF, 1'b1);
    check("ff_done", 8'h00, 7, 0, 0);
    step(1'b1, 8'h00, 1'b0);
    check("ff_idle3", 8'h00, 7, 0, 0);

    // Lone requester 7 expires; mask is overridden and then cleared on regrant.
    step(1'b1, 8'h80, 1'b0);
    check("solo_win", 8'h80, 7, 1, 0);
    for (int c = 0; c < 15; c++) step(1'b1, 8'h80, 1'b0);
    check("solo_last", 8'h80, 7, 1, 0);
    step(1'b1, 8'h80, 1'b0);
    check("solo_preempt", 8'h00, 7, 0, 1);
    step(1'b1, 8'h80, 1'b0);
    check("solo_idle", 8'h00, 7, 0, 0);
    step(1'b1, 8'h80, 1'b0);
    check("solo_override", 8'h80, 7, 1, 0);
    step(1'b1, 8'h80, 1'b1);
    check("solo_done", 8'h00, 7, 0, 0);
    step(1'b1, 8'h81, 1'b0);
    check("solo_idle2", 8'h00, 7, 0, 0);
    step(1'b1, 8'h81, 1'b0);
    check("solo_mask_cleared", 8'h80, 7, 1, 0);
    step(1'b1, 8'h00, 1'b0);
    check("solo_drop", 8'h00, 7, 0, 0);
    step(1'b1, 8'h00, 1'b0);
    check("solo_idle3", 8'h00, 7, 0, 0);

    // done coincides with counter==MAX_HOLD: no preempt, no mask.
    step(1'b1, 8'h02, 1'b0);
    check("tie_win", 8'h02, 1, 1, 0);
    for (int c = 0; c < 15; c++) step(1'b1, 8'h02, 1'b0);
    check("tie_last", 8'h02, 1, 1, 0);
    step(1'b1, 8'h02, 1'b1);
    check("tie_done", 8'h00, 1, 0, 0);
    step(1'b1, 8'h03, 1'b0);
    check("tie_idle", 8'h00, 1, 0, 0);
    step(1'b1, 8'h03, 1'b0);
    check("tie_no_mask", 8'h02, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Eight-requester fixed-priority bus arbiter with bounded tenure. The highest-index pending requester wins; its grant is held until it signals done, drops its request, or exceeds MAX_HOLD cycles. A preempted requester is masked for one arbitration round so a lower-priority requester can get through. The arbiter sits between the eight bus masters and the shared resource, and reuses the existing 8→3 priority encoder for winner selection.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles per tenure. Legal range 2..255.
- HOLD_W, default $clog2(MAX_HOLD+1): derived width of the tenure counter. Do not override.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- req  in  8  request vector; bit i = requester i; higher index = higher priority
- done  in  1  end-of-tenure strobe from the current grantee; ignored unless busy=1
- grant  out  8  one-hot grant, registered; all zeros when no tenure is active
- grant_idx  out  3  index of the current grantee; holds its last value when grant=0
- busy  out  1  high exactly while grant≠0
- preempt  out  1  one-cycle pulse; the tenure was ended by MAX_HOLD expiry

## Operation
- States:
  - IDLE: no grant.
  - BUSY: tenure active.
  - GAP: one mandatory turnaround cycle, grant=0.
- Arbitration in IDLE:
  - eligible = req & ~mask.
  - If eligible≠0: the winner is the highest set bit of eligible.
  - Else if req≠0: the winner is the highest set bit of req (mask overridden).
  - Else: stay in IDLE.
- On a win:
  - load grant/grant_idx, set the counter to 1, clear mask, go to BUSY.
- BUSY, priority order per cycle:
  - (1) done=1 or req[grant_idx]=0 → clear grant, go to GAP, no preempt.
  - (2) counter==MAX_HOLD → clear grant, set mask[grant_idx], pulse preempt, go to GAP.
  - (3) otherwise counter+1, stay in BUSY.
- GAP → IDLE unconditionally. Requests seen during GAP are arbitrated in IDLE.
- Higher-priority requests arriving during BUSY never preempt the grantee; only rules (1)/(2) end a tenure.
- mask is a single-bit-set or zero vector. It is cleared on every new grant, so a requester is penalised for at most one round.
- Reset, including mid-tenure: state=IDLE, grant=0, grant_idx=0, busy=0, preempt=0, mask=0, counter=0. The grant drops on the cycle after rst_n is sampled low.

## Timing
- Request latency: req sampled in IDLE at edge t → grant valid after edge t+1 (one cycle).
- Release: done sampled at edge t → grant=0 after t+1 (GAP); IDLE after t+2; the earliest next grant is after t+3.
- Max tenure: grant high for exactly MAX_HOLD cycles when done never arrives. preempt is high in the first GAP cycle only.
- done and expiry in the same cycle: done wins and preempt stays 0.
- grant, grant_idx, busy and preempt are all flop outputs, with no combinational path from req/done.
- Minimum bus-idle between tenures: 2 cycles (GAP + IDLE).

## Structure
- Package priority_arbiter_pkg:
  - state enum {IDLE, BUSY, GAP}
  - localparams NREQ=8, IDX_W=3
- Sub-module: priority_deshiphrator, instantiated once on the selected vector (eligible or req) to produce the winner index. Validity is the OR-reduction of that vector, computed in the arbiter because the encoder returns 0 for both "bit 0" and "none".
- The one-hot grant is decoded from the registered index: grant = busy << grant_idx.

## Test plan
- Reset then req=8'b0010_0100 → after 1 cycle grant=8'b0010_0000, grant_idx=5, busy=1. done pulse → grant=0 for 2 cycles. With req[2] still set → grant=8'b0000_0100.
- req=8'hFF, done never asserted, MAX_HOLD=16 → grant[7] high exactly 16 cycles, preempt pulse, then grant_idx=6 (7 masked). After that tenure ends, index 7 wins again.
- req[7] drop mid-tenure while req[3]=1 → grant released the next cycle with preempt=0; the next grant goes to 3.
- req=8'b1000_0000 only, expiry preemption → mask overridden, grant_idx=7 again after GAP+IDLE, mask cleared.
- done and counter==MAX_HOLD in the same cycle → preempt stays 0 and mask stays 0.
- rst_n low during BUSY → grant=0, busy=0, grant_idx=0 on the next cycle. After release with req=8'h01 → grant=8'h01 one cycle later.
